// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register scoreboard with mem/ALU writeback arbitration
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      Ra,
  input  logic [4:0]      Rb,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wb,
  output logic            IF_ID_Write,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            reg_wr,
  output logic [4:0]      reg_write_addr,
  output logic [XLEN-1:0] reg_write_data,
  output logic [5:0]      pending_cnt
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e      buf_state_q, buf_state_d;
  logic [4:0]      buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_data_q, buf_data_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            reg_wr_q, reg_wr_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [5:0]      cnt_q, cnt_d;

  logic            hazard;
  logic            issue_set;
  logic            commit_en;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;

  function automatic logic is_pending(input logic [NREG-1:0] vec, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREG) && vec[a];
  endfunction

  // Hazard looks only at the pre-edge scoreboard, so a same-cycle commit never bypasses a stall.
  always_comb begin
    hazard = issue_valid & (is_pending(pending_q, Ra) | is_pending(pending_q, Rb) |
                            (issue_wb & is_pending(pending_q, issue_rd)));
  end

  assign IF_ID_Write  = ~hazard;
  assign alu_wb_ready = (buf_state_q == BUF_EMPTY);
  assign issue_set    = issue_valid & ~hazard & issue_wb & (issue_rd != 5'd0);

  // Writeback select: mem first, then the parked ALU entry, then a fresh ALU request.
  always_comb begin
    buf_state_d = buf_state_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    commit_en   = 1'b0;
    commit_rd   = 5'd0;
    commit_data = '0;
    if (mem_wb_valid) begin
      commit_en   = 1'b1;
      commit_rd   = mem_wb_rd;
      commit_data = mem_wb_data;
      if (alu_wb_valid && buf_state_q == BUF_EMPTY) begin
        buf_state_d = BUF_FULL;
        buf_rd_d    = alu_wb_rd;
        buf_data_d  = alu_wb_data;
      end
    end else if (buf_state_q == BUF_FULL) begin
      commit_en   = 1'b1;
      commit_rd   = buf_rd_q;
      commit_data = buf_data_q;
      buf_state_d = BUF_EMPTY;
    end else if (alu_wb_valid) begin
      commit_en   = 1'b1;
      commit_rd   = alu_wb_rd;
      commit_data = alu_wb_data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    reg_wr_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    if (commit_en && commit_rd != 5'd0) begin
      reg_wr_d = 1'b1;
      addr_d   = commit_rd;
      data_d   = commit_data;
      if (int'(commit_rd) < NREG) begin
        pending_d[commit_rd] = 1'b0;
      end
    end
    // Applied after the clear so a same-edge set always wins.
    if (issue_set && int'(issue_rd) < NREG) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = 6'd0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + 6'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_state_q <= BUF_EMPTY;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= '0;
      pending_q   <= '0;
      reg_wr_q    <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= '0;
      cnt_q       <= 6'd0;
    end else begin
      buf_state_q <= buf_state_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      pending_q   <= pending_d;
      reg_wr_q    <= reg_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign reg_wr         = reg_wr_q;
  assign reg_write_addr = addr_q;
  assign reg_write_data = data_q;
  assign pending_cnt    = cnt_q;

endmodule
